// File: rtl/prgrom_load_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : prgrom_load_sched_if
// Description : Fetch, loader and memory-port signals of the program-memory
//               port scheduler.
// Revision    : 1.0
// ============================================================================
interface prgrom_load_sched_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] fetch_addr;
    logic              ld_req;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_end;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              ld_busy;
    logic [ADDR_W:0]   ld_words;
    logic              ld_err;

    modport master (
        output fetch_addr, ld_req, ld_valid, ld_byte, ld_end,
        input  mem_addr, mem_we, mem_wdata, cpu_hold, ld_busy, ld_words, ld_err
    );

    modport slave (
        input  fetch_addr, ld_req, ld_valid, ld_byte, ld_end,
        output mem_addr, mem_we, mem_wdata, cpu_hold, ld_busy, ld_words, ld_err
    );
endinterface
`default_nettype wire

// File: rtl/prgrom_load_sched.sv
`default_nettype none
// ============================================================================
// Module      : prgrom_load_sched
// Description : Owns the instruction-memory port; passes fetch addresses in
//               run mode, packs loader bytes into words and writes them in
//               load mode.
// Revision    : 1.0
// ============================================================================
module prgrom_load_sched #(
    parameter int ADDR_W       = 14,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic            clock,
    input  wire logic            reset,
    prgrom_load_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [3:0]        c_FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_PTR_MAX    = '1;

    state_t            r_state,     w_state_nxt;
    logic [1:0]        r_bytecnt,   w_bytecnt_nxt;
    logic [ADDR_W-1:0] r_wptr,      w_wptr_nxt;
    logic [31:0]       r_asm,       w_asm_nxt;
    logic [31:0]       r_wdata,     w_wdata_nxt;
    logic [ADDR_W:0]   r_words,     w_words_nxt;
    logic              r_err,       w_err_nxt;
    logic              r_end_flag,  w_end_flag_nxt;
    logic              r_end_pend,  w_end_pend_nxt;
    logic              r_full,      w_full_nxt;
    logic [3:0]        r_flush_cnt, w_flush_cnt_nxt;

    logic [31:0]       w_asm_byte;
    logic [31:0]       w_asm_after;
    logic [1:0]        w_cnt_after;
    logic              w_end;
    logic              w_at_max;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_bytecnt   <= 2'd0;
            r_wptr      <= '0;
            r_asm       <= 32'd0;
            r_wdata     <= 32'd0;
            r_words     <= '0;
            r_err       <= 1'b0;
            r_end_flag  <= 1'b0;
            r_end_pend  <= 1'b0;
            r_full      <= 1'b0;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_bytecnt   <= w_bytecnt_nxt;
            r_wptr      <= w_wptr_nxt;
            r_asm       <= w_asm_nxt;
            r_wdata     <= w_wdata_nxt;
            r_words     <= w_words_nxt;
            r_err       <= w_err_nxt;
            r_end_flag  <= w_end_flag_nxt;
            r_end_pend  <= w_end_pend_nxt;
            r_full      <= w_full_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bytecnt_nxt   = r_bytecnt;
        w_wptr_nxt      = r_wptr;
        w_asm_nxt       = r_asm;
        w_wdata_nxt     = r_wdata;
        w_words_nxt     = r_words;
        w_err_nxt       = r_err;
        w_end_flag_nxt  = r_end_flag;
        w_end_pend_nxt  = r_end_pend;
        w_full_nxt      = r_full;
        w_flush_cnt_nxt = r_flush_cnt;

        w_asm_byte = r_asm;
        w_asm_byte[{r_bytecnt, 3'b000} +: 8] = bus.ld_byte;
        w_asm_after = bus.ld_valid ? w_asm_byte : r_asm;
        w_cnt_after = bus.ld_valid ? r_bytecnt + 2'd1 : r_bytecnt;
        w_end       = bus.ld_end | r_end_pend;
        w_at_max    = (r_wptr == c_PTR_MAX);

        case (r_state)
            S_RUN: begin
                if (bus.ld_req) begin
                    w_state_nxt    = S_LOAD;
                    w_bytecnt_nxt  = 2'd0;
                    w_wptr_nxt     = '0;
                    w_asm_nxt      = 32'd0;
                    w_words_nxt    = '0;
                    w_err_nxt      = 1'b0;
                    w_end_flag_nxt = 1'b0;
                    w_end_pend_nxt = 1'b0;
                    w_full_nxt     = 1'b0;
                end
            end
            S_LOAD: begin
                w_end_pend_nxt = 1'b0;
                if (r_full) begin
                    // Memory is full: bytes are dropped, only the end strobe matters.
                    if (bus.ld_valid) w_err_nxt = 1'b1;
                    if (w_end) begin
                        w_state_nxt     = S_FLUSH;
                        w_flush_cnt_nxt = c_FLUSH_INIT;
                    end
                end else if (bus.ld_valid && (r_bytecnt == 2'd3)) begin
                    w_wdata_nxt    = w_asm_byte;
                    w_asm_nxt      = 32'd0;
                    w_bytecnt_nxt  = 2'd0;
                    w_end_flag_nxt = w_end;
                    w_state_nxt    = S_WRITE;
                end else if (w_end) begin
                    if (w_cnt_after == 2'd0) begin
                        w_state_nxt     = S_FLUSH;
                        w_flush_cnt_nxt = c_FLUSH_INIT;
                    end else begin
                        // Partial final word: upper lanes are already zero.
                        w_wdata_nxt    = w_asm_after;
                        w_asm_nxt      = 32'd0;
                        w_bytecnt_nxt  = 2'd0;
                        w_err_nxt      = 1'b1;
                        w_end_flag_nxt = 1'b1;
                        w_state_nxt    = S_WRITE;
                    end
                end else begin
                    w_asm_nxt     = w_asm_after;
                    w_bytecnt_nxt = w_cnt_after;
                end
            end
            S_WRITE: begin
                w_words_nxt    = r_words + (ADDR_W+1)'(1);
                w_wptr_nxt     = w_at_max ? r_wptr : r_wptr + ADDR_W'(1);
                w_full_nxt     = w_at_max;
                w_end_flag_nxt = 1'b0;
                if (bus.ld_end) w_end_pend_nxt = 1'b1;
                if (bus.ld_valid && !r_end_flag) begin
                    if (w_at_max) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_asm_nxt     = w_asm_byte;
                        w_bytecnt_nxt = r_bytecnt + 2'd1;
                    end
                end
                if (r_end_flag) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = c_FLUSH_INIT;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == 4'd0) w_state_nxt = S_RUN;
                else                     w_flush_cnt_nxt = r_flush_cnt - 4'd1;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        case (r_state)
            S_RUN:   bus.mem_addr = bus.fetch_addr;
            S_FLUSH: bus.mem_addr = '0;
            default: bus.mem_addr = r_wptr;
        endcase
    end

    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_hold  = (r_state != S_RUN);
    assign bus.ld_busy   = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign bus.ld_words  = r_words;
    assign bus.ld_err    = r_err;

endmodule
`default_nettype wire
